wb_master_arbiter: RTL
======================

Name: wb_master_arbiter

Overview:
- Shares the single wishbone slave-side bus between the two system masters: CPU MMU (master 0) and disk DMA (master 1).
- Sits between the masters and the existing wishbone address decode/slave fabric.
- Grants one master per bus cycle: DMA has priority, with a bounded-starvation guarantee for the MMU.
- Includes a per-cycle watchdog that terminates hung transfers with an error pulse.

Parameters:
- DMA_MAX, 4: max consecutive DMA grants while the MMU is requesting; range 1..15.
- TIMEOUT, 64: cycles in a grant state without s_ack before forced termination; range 2..255.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- m_mmu_cyc  in  1  MMU request; held high until ack
- m_mmu_we  in  1  MMU write enable
- m_mmu_strb  in  4  MMU byte strobes
- m_mmu_addr  in  32  MMU address
- m_mmu_data_i  in  32  MMU write data
- m_mmu_ack  out  1  MMU transfer done (one cycle)
- m_mmu_data_o  out  32  MMU read data
- m_dma_cyc, m_dma_we, m_dma_strb, m_dma_addr, m_dma_data_i, m_dma_ack, m_dma_data_o: same as MMU set, for DMA
- s_cyc  out  1  shared bus cycle
- s_we  out  1  shared write enable
- s_strb  out  4  shared strobes
- s_addr  out  32  shared address
- s_data_o  out  32  shared write data
- s_ack  in  1  slave ack
- s_data_i  in  32  slave read data
- gnt  out  2  one-hot grant: bit0 = MMU, bit1 = DMA
- bus_err  out  1  one-cycle pulse on watchdog termination

Behaviour:
- Reset (async, rst_n=0): state=IDLE, gnt=2'b00, dma_cnt=0, wd_cnt=0.
  - s_cyc, s_we, s_strb, s_addr, s_data_o, both acks, bus_err all 0.
  - m_*_data_o = 0.
  - Reset mid-transfer abandons the cycle; no ack is issued.
- States: IDLE, GNT_MMU, GNT_DMA. State and gnt are registered; gnt mirrors the state.
- IDLE arbitration, next state:
  - DMA only -> GNT_DMA.
  - MMU only -> GNT_MMU.
  - Both requesting: GNT_MMU if dma_cnt == DMA_MAX, else GNT_DMA.
  - Neither -> stay IDLE.
- Arbitration latency: 1 cycle from cyc rise (in IDLE) to s_cyc rise.
- s_* outputs in a grant state: combinational mux of the granted master's cyc/we/strb/addr/data.
  - In IDLE: s_cyc=0, s_we=0, s_strb=0; addr/data driven from MMU inputs (don't-care for slaves).
- m_*_data_o: both driven with s_data_i while that master is granted, else 0.
- Ack forwarding: m_x_ack = s_ack & granted(x) & m_x_cyc. This is combinational, zero added latency.
- On forwarded ack, next state = IDLE. A master holding cyc re-arbitrates in IDLE, so there is a one-cycle bubble between transfers.
- Abort: granted master drops cyc before ack -> IDLE next cycle; no ack, no err.
- s_ack in IDLE, or with the granted cyc low: ignored, not forwarded.
- dma_cnt, updated on each grant decision in IDLE:
  - +1 (saturating at DMA_MAX) when DMA is granted while MMU is requesting.
  - Cleared when MMU is granted.
  - Cleared when DMA is granted with MMU idle.
  - Worst-case MMU wait: DMA_MAX DMA transfers.
- Watchdog:
  - wd_cnt clears on entering a grant state and increments each grant cycle.
  - If wd_cnt == TIMEOUT-1 and s_ack=0: assert granted m_x_ack=1, m_x_data_o=32'hDEAD_BEEF and bus_err=1 for that cycle; s_cyc stays high that cycle; next state IDLE.
  - s_ack in the same cycle as expiry: normal ack, bus_err=0.
- Widths: dma_cnt is 4 bits; wd_cnt is 8 bits. No wrap is possible, since expiry occurs first.

Decomposition:
- Shared include (wb_arb_defs.vh) holds:
  - State encodings: IDLE=2'd0, GNT_MMU=2'd1, GNT_DMA=2'd2.
  - Grant one-hot constants.
  - Error data constant 32'hDEAD_BEEF.
- One natural sub-module: wb_arb_watchdog (8-bit counter with clear/enable and expire output).
- FSM, fairness counter and output muxing stay in the top.

Test Plan:
- MMU-only read: MMU cyc=1, addr=32'h0000_1000 at t0; slave acks at t3 with data 32'h1234_5678 -> s_cyc=1 from t1; m_mmu_ack=1 and m_mmu_data_o=32'h1234_5678 at t3; gnt=01 t1..t3; IDLE at t4.
- Simultaneous requests: both cyc=1 at t0 -> gnt=10 at t1; MMU ack never asserted while DMA is granted.
- Fairness: both hold cyc continuously, slave acks 1 cycle after each s_cyc rise -> grant order DMA,DMA,DMA,DMA,MMU,DMA...
- Watchdog: DMA granted, no s_ack -> at cycle 64 of the grant, m_dma_ack=1, m_dma_data_o=32'hDEAD_BEEF, bus_err=1 for one cycle; then IDLE.
- Abort: MMU granted, MMU drops cyc after 2 cycles; stray s_ack one cycle later -> no m_mmu_ack, no bus_err, state IDLE.
- Reset mid-transfer: rst_n=0 while DMA is granted -> s_cyc, gnt, all acks 0 immediately (asynchronous); after release, a pending MMU request is granted 1 cycle later.

Source files
------------

// File: rtl/wb_master_arbiter_pkg.sv
// Shared definitions for the two-master wishbone arbiter: state encodings,
// one-hot grant constants, and the data word returned on watchdog termination.
// Ports: none (package only).
package wb_master_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GNT_MMU = 2'd1,
        ST_GNT_DMA = 2'd2
    } state_e;

    localparam logic [1:0]  GNT_NONE = 2'b00;
    localparam logic [1:0]  GNT_MMU  = 2'b01;
    localparam logic [1:0]  GNT_DMA  = 2'b10;

    localparam logic [31:0] ERR_DATA = 32'hDEAD_BEEF;

    // Grant vector is a pure function of the state so the two can never disagree.
    function automatic logic [1:0] gnt_of(input state_e s);
        case (s)
            ST_GNT_MMU: gnt_of = GNT_MMU;
            ST_GNT_DMA: gnt_of = GNT_DMA;
            default:    gnt_of = GNT_NONE;
        endcase
    endfunction

endpackage

// File: rtl/wb_arb_watchdog.sv
// Per-transfer watchdog: 8-bit cycle counter with clear/enable, flags expiry
// when the count reaches TIMEOUT-1 while enabled. No added latency; no backpressure.
// Ports: clk, rst_n, clr (restart count), en (count this cycle), expire (comb flag).
module wb_arb_watchdog #(
    parameter int TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam logic [7:0] LAST = 8'(TIMEOUT - 1);

    logic [7:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr)
            cnt_d = 8'd0;
        else if (en)
            cnt_d = cnt_q + 8'd1;
    end

    // The arbiter leaves the grant state on expiry, so the count never wraps.
    assign expire = en && (cnt_q == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt_q <= 8'd0;
        else
            cnt_q <= cnt_d;
    end

endmodule

// File: rtl/wb_master_arbiter.sv
// Two-master wishbone arbiter (MMU=master 0, DMA=master 1) onto one slave bus,
// DMA priority with bounded MMU starvation. 1-cycle grant latency, comb ack path;
// masters are stalled by holding cyc until ack; watchdog forces ack+bus_err on hang.
module wb_master_arbiter
    import wb_master_arbiter_pkg::*;
#(
    parameter int DMA_MAX = 4,
    parameter int TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        m_mmu_cyc,
    input  logic        m_mmu_we,
    input  logic [3:0]  m_mmu_strb,
    input  logic [31:0] m_mmu_addr,
    input  logic [31:0] m_mmu_data_i,
    output logic        m_mmu_ack,
    output logic [31:0] m_mmu_data_o,
    input  logic        m_dma_cyc,
    input  logic        m_dma_we,
    input  logic [3:0]  m_dma_strb,
    input  logic [31:0] m_dma_addr,
    input  logic [31:0] m_dma_data_i,
    output logic        m_dma_ack,
    output logic [31:0] m_dma_data_o,
    output logic        s_cyc,
    output logic        s_we,
    output logic [3:0]  s_strb,
    output logic [31:0] s_addr,
    output logic [31:0] s_data_o,
    input  logic        s_ack,
    input  logic [31:0] s_data_i,
    output logic [1:0]  gnt,
    output logic        bus_err
);

    localparam logic [3:0] DMA_MAX_C = 4'(DMA_MAX);

    state_e     state_q, state_d;
    logic [1:0] gnt_q, gnt_d;
    logic [3:0] dma_cnt_q, dma_cnt_d;

    logic mmu_gnt, dma_gnt, cyc_g, wd_exp, err_term;
    logic [31:0] rd_data;

    assign mmu_gnt = gnt_q[0];
    assign dma_gnt = gnt_q[1];
    assign cyc_g   = (mmu_gnt & m_mmu_cyc) | (dma_gnt & m_dma_cyc);

    // Counter idles at zero between grants, so every grant starts from zero.
    wb_arb_watchdog #(.TIMEOUT(TIMEOUT)) u_wd (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (state_q == ST_IDLE),
        .en     (state_q != ST_IDLE),
        .expire (wd_exp)
    );

    // A real ack in the expiry cycle wins; only a missing ack is an error.
    assign err_term = wd_exp & cyc_g & ~s_ack;
    assign rd_data  = err_term ? ERR_DATA : s_data_i;

    always_comb begin
        state_d   = state_q;
        dma_cnt_d = dma_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (m_dma_cyc && (!m_mmu_cyc || dma_cnt_q != DMA_MAX_C)) begin
                    state_d = ST_GNT_DMA;
                    // dma_cnt_q < DMA_MAX here whenever the MMU is waiting,
                    // so the increment saturates at DMA_MAX by construction.
                    dma_cnt_d = m_mmu_cyc ? dma_cnt_q + 4'd1 : 4'd0;
                end else if (m_mmu_cyc) begin
                    state_d   = ST_GNT_MMU;
                    dma_cnt_d = 4'd0;
                end
            end
            ST_GNT_MMU, ST_GNT_DMA: begin
                // Abort (cyc dropped), normal ack, or watchdog all end the grant.
                if (!cyc_g || s_ack || wd_exp)
                    state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        gnt_d = gnt_of(state_d);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            gnt_q     <= GNT_NONE;
            dma_cnt_q <= 4'd0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            dma_cnt_q <= dma_cnt_d;
        end
    end

    // Slave-side mux; address/data fall back to the MMU when idle (slaves ignore them).
    assign s_cyc    = cyc_g;
    assign s_we     = (dma_gnt & m_dma_we) | (mmu_gnt & m_mmu_we);
    assign s_strb   = dma_gnt ? m_dma_strb : (mmu_gnt ? m_mmu_strb : 4'd0);
    assign s_addr   = dma_gnt ? m_dma_addr   : m_mmu_addr;
    assign s_data_o = dma_gnt ? m_dma_data_i : m_mmu_data_i;

    assign m_mmu_ack    = mmu_gnt & m_mmu_cyc & (s_ack | wd_exp);
    assign m_dma_ack    = dma_gnt & m_dma_cyc & (s_ack | wd_exp);
    assign m_mmu_data_o = mmu_gnt ? rd_data : 32'd0;
    assign m_dma_data_o = dma_gnt ? rd_data : 32'd0;
    assign gnt          = gnt_q;
    assign bus_err      = err_term;

endmodule
